uv_spi_txq_pk: RTL and testbench



---
 rtl/uv_spi_txq_pk_pkg.sv | 32 +++
 rtl/uv_spi_txq_pk_if.sv | 39 +++
 rtl/uv_spi_txq_pk_unpk.sv | 71 +++++++
 rtl/uv_spi_txq_pk.sv | 115 +++++++++++
 tb/tb_uv_spi_txq_pk.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uv_spi_txq_pk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uv_spi_txq_pk_pkg
// Description : Shared frame-size encodings, frames-per-word constants and
//               a helper that returns the last frame index for a frame size.
// Revision    : 1.0 - initial release
// ============================================================================
package uv_spi_txq_pk_pkg;

    // Frame-size encodings; 2'd3 behaves as a full word
    localparam logic [1:0] UV_SPI_FRM_Q = 2'd0;
    localparam logic [1:0] UV_SPI_FRM_H = 2'd1;
    localparam logic [1:0] UV_SPI_FRM_W = 2'd2;

    // Frames per bus word for each frame size
    localparam int UV_SPI_FPW_Q = 4;
    localparam int UV_SPI_FPW_H = 2;
    localparam int UV_SPI_FPW_W = 1;

    typedef logic [1:0] fidx_t;

    // Index of the final frame in a word for the given frame size
    function automatic fidx_t frm_last(input logic [1:0] sz);
        case (sz)
            UV_SPI_FRM_Q: return fidx_t'(UV_SPI_FPW_Q - 1);
            UV_SPI_FRM_H: return fidx_t'(UV_SPI_FPW_H - 1);
            default:      return fidx_t'(UV_SPI_FPW_W - 1);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uv_spi_txq_pk_if.sv
`default_nettype none
// ============================================================================
// Module      : uv_spi_txq_pk_if
// Description : Register-side enqueue, shifter-side dequeue, configuration
//               and status signals of the SPI TX queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface uv_spi_txq_pk_if #(
    parameter int QUE_AW = 3,
    parameter int QUE_DW = 32
);
    logic                enq_rdy;
    logic                enq_vld;
    logic [QUE_DW-1:0]   enq_dat;
    logic                deq_rdy;
    logic                deq_vld;
    logic [QUE_DW-1:0]   deq_dat;
    logic [1:0]          frm_sz;
    logic                msb_fst;
    logic                que_clr;
    logic [QUE_AW:0]     que_thr;
    logic [QUE_AW:0]     que_len;
    logic                thr_irq;
    logic                ovf_err;
    logic                udf_err;

    // Queue side
    modport slave (
        input  enq_vld, enq_dat, deq_vld, frm_sz, msb_fst, que_clr, que_thr,
        output enq_rdy, deq_rdy, deq_dat, que_len, thr_irq, ovf_err, udf_err
    );

    // Controller / shifter side
    modport master (
        output enq_vld, enq_dat, deq_vld, frm_sz, msb_fst, que_clr, que_thr,
        input  enq_rdy, deq_rdy, deq_dat, que_len, thr_irq, ovf_err, udf_err
    );
endinterface
`default_nettype wire

// File: rtl/uv_spi_txq_pk_unpk.sv
`default_nettype none
// ============================================================================
// Module      : uv_spi_txq_unpk
// Description : Frame unpacker. Selects the current frame of the head word
//               (right-aligned, zero-extended) and tracks the frame index.
//               Raises word_pop_o when the last frame of the word is popped.
// Revision    : 1.0 - initial release
// ============================================================================
module uv_spi_txq_unpk
    import uv_spi_txq_pk_pkg::*;
#(
    parameter int QUE_DW = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [QUE_DW-1:0] word_i,
    input  wire logic [1:0]        frm_sz_i,
    input  wire logic              msb_fst_i,
    input  wire logic              pop_i,
    input  wire logic              clr_i,
    output logic      [QUE_DW-1:0] deq_dat_o,
    output logic                   word_pop_o
);
    localparam int QW = QUE_DW / 4;
    localparam int HW = QUE_DW / 2;

    logic [1:0] frm_sz_q;
    fidx_t      fidx_q;
    fidx_t      fidx_d;
    logic       w_last;

    assign w_last     = (fidx_q == frm_last(frm_sz_q));
    assign word_pop_o = pop_i && w_last;

    // Next frame index: flush or size change restarts at frame 0
    always_comb begin
        fidx_d = fidx_q;
        if (clr_i || (frm_sz_i != frm_sz_q)) begin
            fidx_d = '0;
        end else if (pop_i) begin
            fidx_d = w_last ? '0 : fidx_q + 1'b1;
        end
    end

    // Frame index and registered frame size
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fidx_q   <= '0;
            frm_sz_q <= UV_SPI_FRM_Q;
        end else begin
            fidx_q   <= fidx_d;
            frm_sz_q <= frm_sz_i;
        end
    end

    // Frame mux; MSB-first order reverses the slot (F-1-k)
    always_comb begin
        logic [1:0] w_qs;
        logic       w_hs;
        deq_dat_o = '0;
        w_qs      = msb_fst_i ? ~fidx_q : fidx_q;
        w_hs      = msb_fst_i ? ~fidx_q[0] : fidx_q[0];
        case (frm_sz_q)
            UV_SPI_FRM_Q: deq_dat_o[QW-1:0] = word_i[int'(w_qs) * QW +: QW];
            UV_SPI_FRM_H: deq_dat_o[HW-1:0] = word_i[int'(w_hs) * HW +: HW];
            default:      deq_dat_o         = word_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/uv_spi_txq_pk.sv
`default_nettype none
// ============================================================================
// Module      : uv_spi_txq_pk
// Description : SPI TX queue with internal word storage, first-word-fall-
//               through read, run-time frame size / frame order, low-
//               watermark interrupt and length reporting.
//               Optional sticky overflow/underflow flags: UV_SPI_TXQ_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uv_spi_txq_pk
    import uv_spi_txq_pk_pkg::*;
#(
    parameter int QUE_AW = 3,
    parameter int QUE_DP = 2**QUE_AW,
    parameter int QUE_DW = 32
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    uv_spi_txq_pk_if.slave  txq
);
    logic [QUE_DW-1:0] mem_q [QUE_DP];
    logic [QUE_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [QUE_AW:0]   rd_ptr_q, rd_ptr_d;
    logic [QUE_AW:0]   que_len_d;
    logic              thr_irq_q;
    logic              w_wr_en;
    logic              w_pop;
    logic              w_word_pop;
    logic [QUE_DW-1:0] w_head;

    // Length falls out of the pointer difference; the extra MSB separates full from empty
    assign txq.que_len = wr_ptr_q - rd_ptr_q;
    assign txq.enq_rdy = (txq.que_len != (QUE_AW+1)'(QUE_DP));
    assign txq.deq_rdy = (txq.que_len != '0);
    assign txq.thr_irq = thr_irq_q;

    assign w_wr_en = txq.enq_vld && txq.enq_rdy && !txq.que_clr;
    assign w_pop   = txq.deq_vld && txq.deq_rdy;
    // Empty queue presents zero rather than stale storage
    assign w_head  = txq.deq_rdy ? mem_q[rd_ptr_q[QUE_AW-1:0]] : '0;

    uv_spi_txq_unpk #(
        .QUE_DW (QUE_DW)
    ) u_unpk (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_i     (w_head),
        .frm_sz_i   (txq.frm_sz),
        .msb_fst_i  (txq.msb_fst),
        .pop_i      (w_pop),
        .clr_i      (txq.que_clr),
        .deq_dat_o  (txq.deq_dat),
        .word_pop_o (w_word_pop)
    );

    // Next pointers; flush dominates write and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (txq.que_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_wr_en)    wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_word_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    assign que_len_d = wr_ptr_d - rd_ptr_d;

    // Pointers and watermark flag; flag tracks next-state length so it aligns with que_len
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            thr_irq_q <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            thr_irq_q <= (que_len_d <= txq.que_thr);
        end
    end

    // Word storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (w_wr_en) mem_q[wr_ptr_q[QUE_AW-1:0]] <= txq.enq_dat;
    end

`ifdef UV_SPI_TXQ_ERR_EN
    logic ovf_err_q;
    logic udf_err_q;

    // Sticky error flags, cleared only by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else if (txq.que_clr) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            if (txq.enq_vld && !txq.enq_rdy) ovf_err_q <= 1'b1;
            if (txq.deq_vld && !txq.deq_rdy) udf_err_q <= 1'b1;
        end
    end

    assign txq.ovf_err = ovf_err_q;
    assign txq.udf_err = udf_err_q;
`else
    assign txq.ovf_err = 1'b0;
    assign txq.udf_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uv_spi_txq_pk.sv
`default_nettype none
// ============================================================================
// Module      : tb_uv_spi_txq_pk
// Description : Self-checking bench for uv_spi_txq_pk: frame-select vector
//               table plus hand-written full / watermark / stream / flush
//               sequences, with a frame scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uv_spi_txq_pk;
    import uv_spi_txq_pk_pkg::*;

    localparam int AW = 3;
    localparam int DP = 8;
    localparam int DW = 32;
`ifdef UV_SPI_TXQ_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uv_spi_txq_pk_if #(.QUE_AW(AW), .QUE_DW(DW)) bus ();

    uv_spi_txq_pk #(.QUE_AW(AW), .QUE_DP(DP), .QUE_DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .txq   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_len  = 0;
    int          m_fidx = 0;
    bit          m_ovf  = 0;
    bit          m_udf  = 0;
    logic [DW-1:0] sb[$];

    typedef struct {
        logic [1:0]    sz;
        logic          msb;
        logic [DW-1:0] word;
        logic [DW-1:0] fr[4];
        int            n;
    } vec_t;
    vec_t tv[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int fpw(input logic [1:0] s);
        if (s == 2'd0) return 4;
        if (s == 2'd1) return 2;
        return 1;
    endfunction

    // Expected frames of a word under the current frame size and order
    task automatic push_word(input logic [DW-1:0] w);
        int F, wd, slot;
        logic [63:0] tmp, mask;
        F    = fpw(bus.frm_sz);
        wd   = DW / F;
        tmp  = 64'(w);
        mask = (64'd1 << wd) - 64'd1;
        for (int k = 0; k < F; k++) begin
            slot = bus.msb_fst ? (F - 1 - k) : k;
            sb.push_back(DW'((tmp >> (slot * wd)) & mask));
        end
    endtask

    // One clock with the currently driven inputs; model follows
    task automatic cyc();
        bit wa, pa;
        int F;
        F  = fpw(bus.frm_sz);
        wa = bus.enq_vld && (m_len != DP) && !bus.que_clr;
        pa = bus.deq_vld && (m_len != 0) && !bus.que_clr;
        if (pa) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL deq_dat: got %0h expected nothing (scoreboard empty)", bus.deq_dat);
            end else begin
                chk("deq_dat", 64'(bus.deq_dat), 64'(sb.pop_front()));
            end
        end
        if (wa) push_word(bus.enq_dat);
        if (bus.enq_vld && m_len == DP) m_ovf = ERR;
        if (bus.deq_vld && m_len == 0)  m_udf = ERR;
        @(posedge clk);
        #1;
        if (bus.que_clr) begin
            m_len = 0; m_fidx = 0; m_ovf = 0; m_udf = 0;
            sb.delete();
        end else begin
            if (pa) begin
                if (m_fidx == F - 1) begin m_fidx = 0; m_len--; end
                else m_fidx++;
            end
            if (wa) m_len++;
        end
    endtask

    task automatic chk_state(input string tag);
        #1;
        chk({tag, ".que_len"}, 64'(bus.que_len), 64'(m_len));
        chk({tag, ".enq_rdy"}, 64'(bus.enq_rdy), 64'(m_len != DP));
        chk({tag, ".deq_rdy"}, 64'(bus.deq_rdy), 64'(m_len != 0));
        chk({tag, ".thr_irq"}, 64'(bus.thr_irq), 64'(m_len <= int'(bus.que_thr)));
        chk({tag, ".ovf_err"}, 64'(bus.ovf_err), 64'(m_ovf));
        chk({tag, ".udf_err"}, 64'(bus.udf_err), 64'(m_udf));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int written;
        tv[0] = '{2'd0, 1'b0, 32'h44332211, '{32'h11, 32'h22, 32'h33, 32'h44}, 4};
        tv[1] = '{2'd1, 1'b1, 32'h44332211, '{32'h4433, 32'h2211, 32'h0, 32'h0}, 2};
        tv[2] = '{2'd2, 1'b0, 32'h44332211, '{32'h44332211, 32'h0, 32'h0, 32'h0}, 1};
        tv[3] = '{2'd0, 1'b1, 32'hA1B2C3D4, '{32'hA1, 32'hB2, 32'hC3, 32'hD4}, 4};
        tv[4] = '{2'd1, 1'b0, 32'hA1B2C3D4, '{32'hC3D4, 32'hA1B2, 32'h0, 32'h0}, 2};
        tv[5] = '{2'd3, 1'b1, 32'hDEADBEEF, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, 1};

        bus.enq_vld = 0; bus.enq_dat = '0; bus.deq_vld = 0;
        bus.frm_sz  = 2'd0; bus.msb_fst = 0; bus.que_clr = 0; bus.que_thr = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst.que_len", 64'(bus.que_len), 64'd0);
        chk("rst.enq_rdy", 64'(bus.enq_rdy), 64'd1);
        chk("rst.deq_rdy", 64'(bus.deq_rdy), 64'd0);
        chk("rst.deq_dat", 64'(bus.deq_dat), 64'd0);
        chk("rst.thr_irq", 64'(bus.thr_irq), 64'd1);
        chk("rst.ovf_err", 64'(bus.ovf_err), 64'd0);
        chk("rst.udf_err", 64'(bus.udf_err), 64'd0);

        // Frame-select vector table
        for (int i = 0; i < 6; i++) begin
            bus.frm_sz = tv[i].sz; bus.msb_fst = tv[i].msb;
            cyc();
            bus.enq_vld = 1; bus.enq_dat = tv[i].word;
            #1;
            chk("vec.rdy_pre", 64'(bus.deq_rdy), 64'd0);
            cyc();
            bus.enq_vld = 0;
            chk_state("vec.loaded");
            for (int k = 0; k < tv[i].n; k++) begin
                #1;
                chk("vec.frame", 64'(bus.deq_dat), 64'(tv[i].fr[k]));
                chk("vec.len_hold", 64'(bus.que_len), 64'd1);
                bus.deq_vld = 1;
                cyc();
                bus.deq_vld = 0;
            end
            chk_state("vec.drained");
        end

        // Fill to full, overflow attempt, write + last-frame pop at full
        bus.frm_sz = 2'd2; bus.msb_fst = 0;
        cyc();
        for (int i = 0; i < DP; i++) begin
            bus.enq_vld = 1; bus.enq_dat = DW'($urandom);
            cyc();
        end
        bus.enq_vld = 0;
        chk_state("full");
        chk("full.enq_rdy", 64'(bus.enq_rdy), 64'd0);
        chk("full.que_len", 64'(bus.que_len), 64'd8);
        bus.enq_vld = 1; bus.enq_dat = 32'hBAD0BAD0;
        cyc();
        bus.enq_vld = 0;
        chk_state("ovf");
        chk("ovf.flag", 64'(bus.ovf_err), 64'(ERR));
        bus.enq_vld = 1; bus.deq_vld = 1; bus.enq_dat = 32'hBAD1BAD1;
        cyc();
        bus.enq_vld = 0; bus.deq_vld = 0;
        chk_state("full_wr_pop");
        chk("full_wr_pop.len", 64'(bus.que_len), 64'd7);
        bus.deq_vld = 1;
        for (int c = 0; c < 20 && m_len > 0; c++) cyc();
        cyc();                      // pop on empty
        bus.deq_vld = 0;
        chk_state("udf");
        chk("udf.flag", 64'(bus.udf_err), 64'(ERR));
        bus.que_clr = 1;
        cyc();
        bus.que_clr = 0;
        chk_state("clr_flags");

        // Low watermark
        bus.que_thr = 4'd2;
        cyc();
        for (int i = 0; i < 4; i++) begin
            bus.enq_vld = 1; bus.enq_dat = DW'($urandom);
            cyc();
            bus.enq_vld = 0;
            chk_state("thr.up");
        end
        chk("thr.at4", 64'(bus.thr_irq), 64'd0);
        for (int i = 0; i < 4; i++) begin
            bus.deq_vld = 1;
            cyc();
            bus.deq_vld = 0;
            chk_state("thr.down");
            if (m_len == 2) chk("thr.at2", 64'(bus.thr_irq), 64'd1);
        end

        // Random stream across pointer wrap
        bus.frm_sz = 2'd0; bus.msb_fst = 1; bus.que_thr = 4'd3;
        cyc();
        written = 0;
        for (int c = 0; c < 3000 && !(written == 20 && m_len == 0); c++) begin
            bus.enq_vld = (written < 20) && ($urandom_range(0, 1) == 1);
            bus.enq_dat = DW'($urandom);
            bus.deq_vld = ($urandom_range(0, 2) != 0);
            if (bus.enq_vld && m_len != DP) written++;
            cyc();
            chk_state("stream");
        end
        bus.enq_vld = 0; bus.deq_vld = 0;
        chk("stream.done", 64'(written == 20 && m_len == 0 && sb.size() == 0), 64'd1);

        // Flush mid-word with pending write and pop
        bus.frm_sz = 2'd0; bus.msb_fst = 0;
        cyc();
        bus.deq_vld = 1;            // underflow to give the flush a flag to clear
        cyc();
        bus.enq_vld = 1; bus.deq_vld = 0; bus.enq_dat = 32'h44332211;
        cyc();
        bus.enq_vld = 0;
        bus.deq_vld = 1;
        cyc();
        cyc();                      // fidx now 2
        bus.que_clr = 1; bus.enq_vld = 1; bus.enq_dat = 32'h55555555;
        cyc();
        bus.que_clr = 0; bus.enq_vld = 0; bus.deq_vld = 0;
        chk_state("clr");
        chk("clr.len", 64'(bus.que_len), 64'd0);
        chk("clr.deq_rdy", 64'(bus.deq_rdy), 64'd0);
        chk("clr.udf", 64'(bus.udf_err), 64'd0);
        bus.enq_vld = 1; bus.enq_dat = 32'hA4A3A2A1;
        cyc();
        bus.enq_vld = 0;
        #1;
        chk("clr.frame0", 64'(bus.deq_dat), 64'hA1);
        bus.deq_vld = 1;
        for (int c = 0; c < 10 && m_len > 0; c++) cyc();
        bus.deq_vld = 0;
        chk_state("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
